// File: rtl/rx_phys_pkg.sv
// rx_phys_pkg: state encoding and lane-slice helpers shared by the RX IDELAY tracker.
package rx_phys_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_PROBE_EARLY,
        ST_PROBE_LATE,
        ST_WAIT,
        ST_COMPARE,
        ST_DECIDE
    } rx_track_state_t;

    function automatic int unsigned tab_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

    function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

    function automatic int unsigned next_lane(input int unsigned lane, input int unsigned lanes);
        return (lane + 32'd1) % lanes;
    endfunction

endpackage

// File: rtl/rx_phys_mismatch_window.sv
// rx_phys_mismatch_window: counts a 2^FILTER_WIDTH-cycle window of master/monitor
// word mismatches for the currently probed lane and reports a sticky hit flag.
module rx_phys_mismatch_window #(
    parameter int FILTER_WIDTH = 8
) (
    input  logic i_clk_200,
    input  logic local_clk_200_rst,
    input  logic i_start,
    input  logic i_abort,
    input  logic i_mismatch,
    output logic o_done,
    output logic o_hit
);

    logic                    r_busy;
    logic                    r_hit;
    logic [FILTER_WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk_200 or negedge local_clk_200_rst) begin
        if (!local_clk_200_rst) begin
            r_busy <= 1'b0;
            r_hit  <= 1'b0;
            r_cnt  <= '0;
        end else if (i_abort) begin
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_hit  <= 1'b0;
            r_cnt  <= '0;
        end else if (r_busy) begin
            r_hit <= r_hit | i_mismatch;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == '1) begin
                r_busy <= 1'b0;
            end
        end
    end

    // The last sample is folded in combinationally so the window is exactly 2^FILTER_WIDTH cycles.
    assign o_done = r_busy && (r_cnt == '1);
    assign o_hit  = r_hit | i_mismatch;

endmodule

// File: rtl/rx_phys_delay_tracker.sv
// rx_phys_delay_tracker: round-robin eye-edge tracker nudging each lane's master IDELAY tap.
// Optional per-lane adjustment counters are built when RX_DELAY_TRACK_STATS_EN is defined.
module rx_phys_delay_tracker
    import rx_phys_pkg::*;
#(
    parameter int LANES        = 4,
    parameter int SERDES_WIDTH = 6,
    parameter int TAB_WIDTH    = 5,
    parameter int OFFSET       = 4,
    parameter int FILTER_WIDTH = 8,
    parameter int WAIT_WIDTH   = 4
) (
    input  logic                          i_clk_200,
    input  logic                          local_clk_200_rst,
    input  logic                          i_enable,
    input  logic [LANES*TAB_WIDTH-1:0]    i_init_delay_tabs,
    input  logic [LANES-1:0]              i_lane_en,
    input  logic [LANES*SERDES_WIDTH-1:0] i_serdes_master,
    input  logic [LANES*SERDES_WIDTH-1:0] i_serdes_monitor,
    output logic [LANES*TAB_WIDTH-1:0]    o_master_delay_tabs,
    output logic [LANES*TAB_WIDTH-1:0]    o_monitor_delay_tabs,
    output logic [LANES-1:0]              o_delay_tabs_update,
    output logic                          o_run,
    output logic [LANES-1:0]              o_fail,
    output logic [LANES*8-1:0]            o_adj_count
);

    localparam int                   TW      = TAB_WIDTH;
    localparam int                   SW      = SERDES_WIDTH;
    localparam int                   LW      = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [TW-1:0]        TAB_MAX = TW'(tab_max(TAB_WIDTH));
    localparam logic [TW-1:0]        OFS     = TW'(OFFSET);

    rx_track_state_t        r_state;
    logic [LANES*TW-1:0]    r_master;
    logic [LANES*TW-1:0]    r_monitor;
    logic [LANES-1:0]       r_update;
    logic [LANES-1:0]       r_fail;
    logic                   r_run;
    logic                   r_en_d;
    logic                   r_second;
    logic                   r_early_hit;
    logic                   r_late_hit;
    logic [LW-1:0]          r_ptr;
    logic [LW-1:0]          r_lane;
    logic [WAIT_WIDTH-1:0]  r_wait;

    logic                   w_rise;
    logic                   w_abort;
    logic                   w_win_start;
    logic                   w_win_done;
    logic                   w_win_hit;
    logic                   w_mismatch;
    logic [LANES-1:0]       w_elig;
    logic                   w_sel_found;
    logic [LW-1:0]          w_sel_lane;
    int unsigned            w_dist;
    int unsigned            w_best;
    logic [TW-1:0]          w_cur;
    logic [TW-1:0]          w_early;
    logic [TW-1:0]          w_late;
    logic [TW-1:0]          w_new;
    logic                   w_changed;
    logic                   w_set_fail;

    assign w_rise      = i_enable & ~r_en_d;
    assign w_abort     = (r_state != ST_IDLE) & ~i_enable;
    assign w_win_start = (r_state == ST_WAIT) & (r_wait == '1) & i_enable;
    assign w_elig      = i_lane_en & ~r_fail;

    assign w_cur      = r_master[lane_lo(32'(r_lane), TW) +: TW];
    assign w_early    = (w_cur >= OFS) ? w_cur - OFS : '0;
    assign w_late     = (w_cur > TAB_MAX - OFS) ? TAB_MAX : w_cur + OFS;
    assign w_mismatch = i_serdes_master[lane_lo(32'(r_lane), SW) +: SW]
                     != i_serdes_monitor[lane_lo(32'(r_lane), SW) +: SW];

    // Round-robin pick: the eligible lane closest to the pointer, counting upward with wrap.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_lane  = '0;
        w_best      = LANES;
        w_dist      = 0;
        for (int unsigned i = 0; i < LANES; i++) begin
            w_dist = (i >= 32'(r_ptr)) ? i - 32'(r_ptr) : i + LANES - 32'(r_ptr);
            if (w_elig[i] && (w_dist < w_best)) begin
                w_best      = w_dist;
                w_sel_found = 1'b1;
                w_sel_lane  = LW'(i);
            end
        end
    end

    always_comb begin
        w_new      = w_cur;
        w_changed  = 1'b0;
        w_set_fail = 1'b0;
        if (i_lane_en[r_lane]) begin
            if (r_early_hit && r_late_hit) begin
                w_set_fail = 1'b1;
            end else if (r_early_hit) begin
                if (w_cur == TAB_MAX) begin
                    w_set_fail = 1'b1;
                end else begin
                    w_new     = w_cur + 1'b1;
                    w_changed = 1'b1;
                end
            end else if (r_late_hit) begin
                if (w_cur == '0) begin
                    w_set_fail = 1'b1;
                end else begin
                    w_new     = w_cur - 1'b1;
                    w_changed = 1'b1;
                end
            end
        end
    end

    rx_phys_mismatch_window #(
        .FILTER_WIDTH (FILTER_WIDTH)
    ) u_window (
        .i_clk_200         (i_clk_200),
        .local_clk_200_rst (local_clk_200_rst),
        .i_start           (w_win_start),
        .i_abort           (w_abort),
        .i_mismatch        (w_mismatch),
        .o_done            (w_win_done),
        .o_hit             (w_win_hit)
    );

    always_ff @(posedge i_clk_200 or negedge local_clk_200_rst) begin
        if (!local_clk_200_rst) begin
            r_state     <= ST_IDLE;
            r_master    <= '0;
            r_monitor   <= '0;
            r_update    <= '0;
            r_fail      <= '0;
            r_run       <= 1'b0;
            r_en_d      <= 1'b0;
            r_second    <= 1'b0;
            r_early_hit <= 1'b0;
            r_late_hit  <= 1'b0;
            r_ptr       <= '0;
            r_lane      <= '0;
            r_wait      <= '0;
        end else begin
            r_en_d   <= i_enable;
            r_update <= '0;
            if (w_abort) begin
                // Discard the in-flight probe; park every monitor back on its master tap.
                r_state   <= ST_IDLE;
                r_run     <= 1'b0;
                r_monitor <= r_master;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_rise) begin
                            r_master  <= i_init_delay_tabs;
                            r_monitor <= i_init_delay_tabs;
                            r_fail    <= '0;
                            r_run     <= 1'b1;
                            r_ptr     <= '0;
                            r_state   <= ST_SELECT;
                        end
                    end
                    ST_SELECT: begin
                        if (w_sel_found) begin
                            r_lane   <= w_sel_lane;
                            r_second <= 1'b0;
                            r_state  <= ST_PROBE_EARLY;
                        end
                    end
                    ST_PROBE_EARLY: begin
                        r_monitor[lane_lo(32'(r_lane), TW) +: TW] <= w_early;
                        r_wait  <= '0;
                        r_state <= ST_WAIT;
                    end
                    ST_PROBE_LATE: begin
                        r_monitor[lane_lo(32'(r_lane), TW) +: TW] <= w_late;
                        r_wait  <= '0;
                        r_state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        r_wait <= r_wait + 1'b1;
                        if (r_wait == '1) begin
                            r_state <= ST_COMPARE;
                        end
                    end
                    ST_COMPARE: begin
                        if (w_win_done) begin
                            if (!r_second) begin
                                r_early_hit <= w_win_hit;
                                r_second    <= 1'b1;
                                r_state     <= ST_PROBE_LATE;
                            end else begin
                                r_late_hit <= w_win_hit;
                                r_state    <= ST_DECIDE;
                            end
                        end
                    end
                    ST_DECIDE: begin
                        r_master[lane_lo(32'(r_lane), TW) +: TW]  <= w_new;
                        r_monitor[lane_lo(32'(r_lane), TW) +: TW] <= w_new;
                        r_update[r_lane] <= w_changed;
                        if (w_set_fail) begin
                            r_fail[r_lane] <= 1'b1;
                        end
                        r_ptr   <= LW'(next_lane(32'(r_lane), LANES));
                        r_state <= ST_SELECT;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef RX_DELAY_TRACK_STATS_EN
    logic [LANES*8-1:0] r_adj_count;
    logic [7:0]         w_adj_cur;

    assign w_adj_cur = r_adj_count[lane_lo(32'(r_lane), 8) +: 8];

    always_ff @(posedge i_clk_200 or negedge local_clk_200_rst) begin
        if (!local_clk_200_rst) begin
            r_adj_count <= '0;
        end else if ((r_state == ST_IDLE) && w_rise) begin
            r_adj_count <= '0;
        end else if ((r_state == ST_DECIDE) && !w_abort && w_changed && (w_adj_cur != 8'hFF)) begin
            r_adj_count[lane_lo(32'(r_lane), 8) +: 8] <= w_adj_cur + 8'd1;
        end
    end

    assign o_adj_count = r_adj_count;
`else
    assign o_adj_count = '0;
`endif

    assign o_master_delay_tabs  = r_master;
    assign o_monitor_delay_tabs = r_monitor;
    assign o_delay_tabs_update  = r_update;
    assign o_run                = r_run;
    assign o_fail               = r_fail;

endmodule

// File: tb/tb_rx_phys_delay_tracker.sv
// tb_rx_phys_delay_tracker: eye-window environment with a service-level reference model.
module tb_rx_phys_delay_tracker;

    localparam int L     = 2;
    localparam int SW    = 6;
    localparam int TW    = 5;
    localparam int OFF   = 4;
    localparam int FW    = 3;
    localparam int WW    = 2;
    localparam int MAXT  = (1 << TW) - 1;
    localparam int S     = 2 * (1 + (1 << WW) + (1 << FW)) + 2;
    localparam int LATEC = 3 + (1 << WW) + (1 << FW);

    logic                clk = 1'b0;
    logic                rst_n;
    logic                i_enable;
    logic [L*TW-1:0]     i_init_delay_tabs;
    logic [L-1:0]        i_lane_en;
    logic [L*SW-1:0]     i_serdes_master;
    logic [L*SW-1:0]     i_serdes_monitor;
    logic [L*TW-1:0]     o_master_delay_tabs;
    logic [L*TW-1:0]     o_monitor_delay_tabs;
    logic [L-1:0]        o_delay_tabs_update;
    logic                o_run;
    logic [L-1:0]        o_fail;
    logic [L*8-1:0]      o_adj_count;

    int n_checks = 0;
    int n_fail   = 0;

    int m_master [L];
    bit m_fail   [L];
    int m_adj    [L];
    int m_ptr;
    int eye_lo   [L];
    int eye_hi   [L];

    rx_phys_delay_tracker #(
        .LANES        (L),
        .SERDES_WIDTH (SW),
        .TAB_WIDTH    (TW),
        .OFFSET       (OFF),
        .FILTER_WIDTH (FW),
        .WAIT_WIDTH   (WW)
    ) dut (
        .i_clk_200            (clk),
        .local_clk_200_rst    (rst_n),
        .i_enable             (i_enable),
        .i_init_delay_tabs    (i_init_delay_tabs),
        .i_lane_en            (i_lane_en),
        .i_serdes_master      (i_serdes_master),
        .i_serdes_monitor     (i_serdes_monitor),
        .o_master_delay_tabs  (o_master_delay_tabs),
        .o_monitor_delay_tabs (o_monitor_delay_tabs),
        .o_delay_tabs_update  (o_delay_tabs_update),
        .o_run                (o_run),
        .o_fail               (o_fail),
        .o_adj_count          (o_adj_count)
    );

    initial forever #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit out_of_eye(input int l, input int tap);
        return (tap < eye_lo[l]) || (tap > eye_hi[l]);
    endfunction

    function automatic logic [L*TW-1:0] exp_taps();
        logic [L*TW-1:0] v;
        v = '0;
        for (int l = 0; l < L; l++) v[l*TW +: TW] = TW'(m_master[l]);
        return v;
    endfunction

    function automatic logic [L-1:0] exp_fail();
        logic [L-1:0] v;
        v = '0;
        for (int l = 0; l < L; l++) v[l] = m_fail[l];
        return v;
    endfunction

    function automatic logic [L*8-1:0] exp_adj();
        logic [L*8-1:0] v;
        v = '0;
`ifdef RX_DELAY_TRACK_STATS_EN
        for (int l = 0; l < L; l++) v[l*8 +: 8] = (m_adj[l] > 255) ? 8'd255 : 8'(m_adj[l]);
`endif
        return v;
    endfunction

    // Environment: a lane's monitor word disagrees whenever its monitor tap sits outside the eye.
    initial forever begin
        @(negedge clk);
        for (int l = 0; l < L; l++) begin
            logic [SW-1:0] w;
            w = SW'($urandom);
            i_serdes_master[l*SW +: SW]  = w;
            i_serdes_monitor[l*SW +: SW] = out_of_eye(l, int'(o_monitor_delay_tabs[l*TW +: TW])) ? ~w : w;
        end
    end

    task automatic check_state(input string tag, input bit run);
        check_eq({tag, "_master"},  64'(o_master_delay_tabs),  64'(exp_taps()));
        check_eq({tag, "_monitor"}, 64'(o_monitor_delay_tabs), 64'(exp_taps()));
        check_eq({tag, "_fail"},    64'(o_fail),               64'(exp_fail()));
        check_eq({tag, "_adj"},     64'(o_adj_count),          64'(exp_adj()));
        check_eq({tag, "_run"},     64'(o_run),                64'(run));
    endtask

    task automatic set_eye(input int l, input int lo, input int hi);
        eye_lo[l] = lo;
        eye_hi[l] = hi;
    endtask

    task automatic start_tracking(input int t0, input int t1);
        i_init_delay_tabs = {TW'(t1), TW'(t0)};
        i_enable = 1'b1;
        m_master[0] = t0;
        m_master[1] = t1;
        for (int l = 0; l < L; l++) begin
            m_fail[l] = 1'b0;
            m_adj[l]  = 0;
        end
        m_ptr = 0;
        @(negedge clk);
        check_eq("start_upd", 64'(o_delay_tabs_update), 64'(0));
        check_state("start", 1'b1);
    endtask

    task automatic stop_tracking();
        @(negedge clk);
        i_enable = 1'b0;
        @(negedge clk);
        check_eq("stop_upd", 64'(o_delay_tabs_update), 64'(0));
        check_state("stop", 1'b0);
    endtask

    // One full lane service; abort_at drops i_enable, drop_at drops the lane enable mid-probe.
    task automatic do_service(input int abort_at, input int drop_at);
        int l, m, e, la;
        bit eh, lh, changed;
        l = -1;
        for (int k = 0; k < L; k++) begin
            int x;
            x = (m_ptr + k) % L;
            if (l < 0 && i_lane_en[x] && !m_fail[x]) l = x;
        end
        if (l < 0) begin
            repeat (5) begin
                @(negedge clk);
                check_eq("idle_upd", 64'(o_delay_tabs_update), 64'(0));
            end
            check_state("idle", 1'b1);
            return;
        end
        m  = m_master[l];
        e  = (m >= OFF) ? m - OFF : 0;
        la = (m + OFF > MAXT) ? MAXT : m + OFF;
        eh = out_of_eye(l, e);
        lh = out_of_eye(l, la);
        for (int c = 1; c <= S; c++) begin
            @(negedge clk);
            if (c < S) check_eq("upd_quiet", 64'(o_delay_tabs_update), 64'(0));
            if (c == 2) check_eq("mon_early", 64'(o_monitor_delay_tabs[l*TW +: TW]), 64'(e));
            if (c == LATEC) check_eq("mon_late", 64'(o_monitor_delay_tabs[l*TW +: TW]), 64'(la));
            if (c == drop_at) i_lane_en[l] = 1'b0;
            if (c == abort_at) begin
                i_enable = 1'b0;
                @(negedge clk);
                check_eq("abort_upd", 64'(o_delay_tabs_update), 64'(0));
                check_state("abort", 1'b0);
                return;
            end
        end
        changed = 1'b0;
        if (i_lane_en[l]) begin
            if (eh && lh) begin
                m_fail[l] = 1'b1;
            end else if (eh) begin
                if (m == MAXT) m_fail[l] = 1'b1;
                else begin m_master[l] = m + 1; changed = 1'b1; end
            end else if (lh) begin
                if (m == 0) m_fail[l] = 1'b1;
                else begin m_master[l] = m - 1; changed = 1'b1; end
            end
        end
        if (changed) m_adj[l]++;
        m_ptr = (l + 1) % L;
        check_eq("upd_pulse", 64'(o_delay_tabs_update), changed ? 64'(1) << l : 64'(0));
        check_state("svc", 1'b1);
        if (drop_at > 0) i_lane_en[l] = 1'b1;
    endtask

    task automatic run_services(input int n);
        for (int i = 0; i < n; i++) do_service(0, 0);
    endtask

    initial begin
        rst_n             = 1'b0;
        i_enable          = 1'b0;
        i_init_delay_tabs = '0;
        i_lane_en         = '1;
        i_serdes_master   = '0;
        i_serdes_monitor  = '0;
        for (int l = 0; l < L; l++) begin
            m_master[l] = 0;
            m_fail[l]   = 1'b0;
            m_adj[l]    = 0;
            set_eye(l, 0, MAXT);
        end
        m_ptr = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_upd", 64'(o_delay_tabs_update), 64'(0));
        check_state("rst", 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check_state("post_rst", 1'b0);

        // Identical words everywhere: nothing moves.
        start_tracking(10, 20);
        run_services(6);
        stop_tracking();

        // Lane 0 drifts up from 12; lane 1 wants to increment past TAB_MAX and fails.
        set_eye(0, 10, MAXT);
        set_eye(1, 28, MAXT);
        start_tracking(12, 31);
        run_services(5);

        // Enable dropped during the first compare window, then re-raised with init 5.
        do_service(10, 0);
        set_eye(0, 0, MAXT);
        set_eye(1, 0, MAXT);
        start_tracking(5, 5);
        run_services(2);
        stop_tracking();

        // Eye narrower than two offsets on lane 0.
        set_eye(0, 14, 16);
        start_tracking(15, 7);
        run_services(4);
        stop_tracking();

        // Decrement at 0 and increment at TAB_MAX both fail; then no lane qualifies.
        set_eye(0, 0, 2);
        set_eye(1, 28, MAXT);
        start_tracking(0, 31);
        run_services(3);
        stop_tracking();

        // Lane enable dropped mid-probe suppresses the decision.
        set_eye(0, 9, 16);
        set_eye(1, 17, 24);
        start_tracking(12, 20);
        do_service(0, 20);
        run_services(3);
        stop_tracking();

        // Randomised eyes, init taps and lane enables.
        for (int r = 0; r < 6; r++) begin
            for (int l = 0; l < L; l++) begin
                int lo, hi;
                lo = int'($urandom_range(0, 24));
                hi = lo + int'($urandom_range(4, 12));
                if (hi > MAXT) hi = MAXT;
                set_eye(l, lo, hi);
            end
            i_lane_en = L'($urandom_range(0, 3));
            start_tracking(int'($urandom_range(0, MAXT)), int'($urandom_range(0, MAXT)));
            run_services(10);
            stop_tracking();
        end
        i_lane_en = '1;

        // Oscillating eyes: every service changes the tap, well past counter saturation.
        set_eye(0, 9, 16);
        set_eye(1, 17, 24);
        start_tracking(12, 20);
        run_services(600);
        stop_tracking();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
